// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one external 8-bit RAM between COUNT requesters with
// round-robin arbitration and periodic refresh bursts.
// Ports: CLK/RESET (sync, active high); per-requester REQ/WE/ADDR/DIN in,
//   ACK/GRANT out, shared DOUT; MEM_* drive the RAM, MEM_DOUT is its read data.
module ram_arbiter #(
  parameter int COUNT            = 5,
  parameter int ADDR_WIDTH       = 21,
  parameter int ACCESS_CYCLES    = 2,
  parameter int REFRESH_INTERVAL = 1024,
  parameter int REFRESH_CYCLES   = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [COUNT-1:0]            REQ,
  input  logic [COUNT-1:0]            WE,
  input  logic [COUNT*ADDR_WIDTH-1:0] ADDR,
  input  logic [COUNT*8-1:0]          DIN,
  output logic [COUNT-1:0]            ACK,
  output logic [7:0]                  DOUT,
  output logic [COUNT-1:0]            GRANT,
  output logic [ADDR_WIDTH-1:0]       MEM_ADDR,
  output logic [7:0]                  MEM_DIN,
  output logic                        MEM_OE_n,
  output logic                        MEM_WE_n,
  output logic                        MEM_RFSH_n,
  input  logic [7:0]                  MEM_DOUT
);

  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, REFRESH, DONE} state_t;

  state_t                state, state_nxt;
  logic [3:0]            phase_cnt;    // cycles already spent in ACCESS/REFRESH
  logic                  phase_last;
  logic [15:0]           rfsh_cnt;
  logic                  rfsh_wrap;
  logic                  rfsh_pending;
  logic [IW-1:0]         last_grant;
  logic [IW-1:0]         winner;
  logic                  winner_vld;
  logic                  wr;           // direction of the access in flight
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_din;
  logic                  sel_we;
  logic [COUNT-1:0]      sel_grant;
  logic                  start_access;
  logic                  end_access;

  assign rfsh_wrap    = (rfsh_cnt == 16'(REFRESH_INTERVAL - 1));
  assign phase_last   = (state == ACCESS) ? (phase_cnt == 4'(ACCESS_CYCLES - 1))
                                          : (phase_cnt == 4'(REFRESH_CYCLES - 1));
  assign start_access = (state == IDLE) && (state_nxt == ACCESS);
  assign end_access   = (state == ACCESS) && (state_nxt == DONE);

  // Round-robin: first requester above last_grant, otherwise wrap to the
  // lowest-numbered active requester.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    for (int i = 0; i < COUNT; i++) begin
      if (!winner_vld && REQ[i] && (IW'(i) > last_grant)) begin
        winner     = IW'(i);
        winner_vld = 1'b1;
      end
    end
    for (int i = 0; i < COUNT; i++) begin
      if (!winner_vld && REQ[i]) begin
        winner     = IW'(i);
        winner_vld = 1'b1;
      end
    end
  end

  // Winner's slices, latched only on the grant edge.
  always_comb begin
    sel_addr  = '0;
    sel_din   = '0;
    sel_we    = 1'b0;
    sel_grant = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (winner == IW'(i)) begin
        sel_addr     = ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din      = DIN[i*8 +: 8];
        sel_we       = WE[i];
        sel_grant[i] = 1'b1;
      end
    end
  end

  // Next-state logic; refresh takes priority over requests in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (rfsh_pending)  state_nxt = REFRESH;
        else if (|REQ)     state_nxt = ACCESS;
      end
      ACCESS:  if (phase_last) state_nxt = DONE;
      REFRESH: if (phase_last) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      rfsh_cnt     <= '0;
      rfsh_pending <= 1'b0;
      last_grant   <= IW'(COUNT - 1);
      wr           <= 1'b0;
      ACK          <= '0;
      GRANT        <= '0;
      DOUT         <= '0;
      MEM_ADDR     <= '0;
      MEM_DIN      <= '0;
      MEM_OE_n     <= 1'b1;
      MEM_WE_n     <= 1'b1;
      MEM_RFSH_n   <= 1'b1;
    end else begin
      state     <= state_nxt;
      phase_cnt <= (state_nxt != state) ? 4'd0 : phase_cnt + 4'd1;

      // Free-running refresh timer; a new wrap wins over consumption so a
      // request is never lost, and a repeated wrap just keeps it set.
      rfsh_cnt <= rfsh_wrap ? 16'd0 : rfsh_cnt + 16'd1;
      if (rfsh_wrap)
        rfsh_pending <= 1'b1;
      else if (state == IDLE && rfsh_pending)
        rfsh_pending <= 1'b0;

      if (start_access) begin
        last_grant <= winner;
        GRANT      <= sel_grant;
        MEM_ADDR   <= sel_addr;
        MEM_DIN    <= sel_din;
        wr         <= sel_we;
        MEM_OE_n   <= sel_we;
        MEM_WE_n   <= !sel_we;
      end else if (state_nxt != ACCESS) begin
        MEM_OE_n <= 1'b1;
        MEM_WE_n <= 1'b1;
        if (state_nxt == IDLE) GRANT <= '0;
      end

      MEM_RFSH_n <= (state_nxt != REFRESH);
      ACK        <= end_access ? GRANT : '0;
      if (end_access && !wr) DOUT <= MEM_DOUT;
    end
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter COUNT, default 5, number of requesters sharing the external RAM (range 2..8).
REQ-002 Parameter ADDR_WIDTH, default 21, RAM byte-address width.
REQ-003 Parameter ACCESS_CYCLES, default 2, cycles a read/write strobe is held active (range 1..15).
REQ-004 Parameter REFRESH_INTERVAL, default 1024, CLK cycles between refresh requests (range 16..65535).
REQ-005 Parameter REFRESH_CYCLES, default 4, cycles MEM_RFSH_n is held low (range 1..15).
REQ-006 CLK  in  1  single system clock; all logic on rising edge.
REQ-007 RESET  in  1  synchronous, active-high reset.
REQ-008 REQ  in  COUNT  per-requester access request, level.
REQ-009 WE  in  COUNT  per-requester direction: 1 = write, 0 = read.
REQ-010 ADDR  in  COUNT*ADDR_WIDTH  packed per-requester address; requester i occupies slice i.
REQ-011 DIN  in  COUNT*8  packed per-requester write data.
REQ-012 ACK  out  COUNT  one-cycle completion pulse, one-hot.
REQ-013 DOUT  out  8  read data, valid while ACK is high, held until the next read completes.
REQ-014 GRANT  out  COUNT  one-hot owner during ACCESS and DONE, else 0.
REQ-015 MEM_ADDR  out  ADDR_WIDTH  RAM address.
REQ-016 MEM_DIN  out  8  RAM write data.
REQ-017 MEM_OE_n  out  1  RAM read strobe, active low.
REQ-018 MEM_WE_n  out  1  RAM write strobe, active low.
REQ-019 MEM_RFSH_n  out  1  RAM refresh strobe, active low.
REQ-020 MEM_DOUT  in  8  RAM read data.

Function
REQ-021 States: IDLE, ACCESS, REFRESH, DONE; every transition is registered.
REQ-022 Refresh counter: free-running 0..REFRESH_INTERVAL-1, wraps to 0; at wrap it sets rfsh_pending, which stays set on a repeated wrap (no double count).
REQ-023 IDLE, rfsh_pending=1 -> REFRESH, clear rfsh_pending; refresh wins over any REQ in the same cycle.
REQ-024 IDLE, rfsh_pending=0, any REQ=1 -> ACCESS, grant the first requester with REQ=1 searching round-robin from last_grant+1 (mod COUNT); update last_grant.
REQ-025 On grant, latch ADDR slice, DIN slice and WE of the winner into MEM_ADDR/MEM_DIN/direction; later changes on requester inputs are ignored until DONE.
REQ-026 ACCESS lasts exactly ACCESS_CYCLES cycles with MEM_OE_n=0 (read) or MEM_WE_n=0 (write); never both.
REQ-027 Read: MEM_DOUT is captured into DOUT at the last ACCESS cycle edge.
REQ-028 DONE lasts one cycle: ACK[winner]=1, strobes high, then -> IDLE.
REQ-029 Latency: REQ high in IDLE cycle k (no refresh pending) -> strobe cycles k+1..k+ACCESS_CYCLES, ACK cycle k+ACCESS_CYCLES+1.
REQ-030 Requesters hold REQ until ACK and drop it on the ACK edge; dropping REQ after grant does not abort the access.
REQ-031 REFRESH lasts REFRESH_CYCLES cycles with MEM_RFSH_n=0, then -> IDLE; no ACK.
REQ-032 Refresh never preempts ACCESS/DONE; the refresh counter keeps running in every state.
REQ-033 MEM_OE_n, MEM_WE_n, MEM_RFSH_n are registered; at most one is low in any cycle.

Reset
REQ-034 At the first edge with RESET=1: state=IDLE, ACK=0, GRANT=0, DOUT=0, MEM_ADDR=0, MEM_DIN=0, all MEM strobes=1, refresh counter=0, rfsh_pending=0, last_grant=COUNT-1 (requester 0 wins first).
REQ-035 RESET during ACCESS/REFRESH aborts the operation; no ACK is issued for it.

Verification
REQ-036 Defaults; REQ[2]=1, WE=0, addr 0x01234, MEM_DOUT=0xA5 -> MEM_OE_n low 2 cycles at 0x01234, ACK[2] 3 cycles after REQ, DOUT=0xA5.
REQ-037 REQ=5'b11111 held, each dropped on its ACK and reasserted -> grant order 0,1,2,3,4,0; each ACK pulses exactly once per access.
REQ-038 REQ[1] asserted in the same cycle rfsh_pending sets -> MEM_RFSH_n low 4 cycles first, then ACCESS for requester 1.
REQ-039 Write to 0x1FFFFF data 0x5A in progress when the counter wraps -> write completes (MEM_WE_n low 2 cycles, ACK), then refresh; RFSH never overlaps WE/OE.
REQ-040 RESET=1 in the second ACCESS cycle -> strobes high the next cycle, no ACK; after release requester 0 wins a simultaneous 0/3 request.
REQ-041 No REQ for 3*REFRESH_INTERVAL cycles -> exactly 3 refresh bursts, spaced 1024 cycles apart.
